dram_burst_responder: RTL and testbench

//  Avalon-MM-style DRAM responder for simulation and bring-up without the external memory.

---
 rtl/dram_burst_responder.sv | 181 ++++++++++++++++++
 tb/tb_dram_burst_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_responder.sv
// dram_burst_responder
// On-chip stand-in for the external DRAM. Burst writes land in a local array,
// single-beat reads come back after a fixed latency, and periodic refresh
// windows stall both ports.
//
// Handshake: a write beat transfers on any cycle where DRAM_Write_Enable=1 and
// DRAM_Wait_Request=0; a read transfers on any cycle where DRAM_Read_Enable=1
// and DRAM_Read_Wait_Request=0. The requester holds its request stable while
// the matching wait request is high. DRAM_Read_Valid pulses once per accepted
// read, in order, exactly RD_LATENCY cycles after that read transferred.
module dram_burst_responder #(
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 25,
  parameter int BURST_W        = 5,
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_LEN    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DRAM_Write_Enable,
  input  logic              DRAM_Write_Burst_Begin,
  input  logic [BURST_W-1:0] DRAM_Write_Burst_Count,
  input  logic [ADDR_W-1:0] DRAM_Write_Addr,
  input  logic [DATA_W-1:0] DRAM_Write_Data,
  output logic              DRAM_Wait_Request,
  input  logic              DRAM_Read_Enable,
  input  logic [ADDR_W-1:0] DRAM_Read_Addr,
  output logic              DRAM_Read_Wait_Request,
  output logic              DRAM_Read_Valid,
  output logic [DATA_W-1:0] DRAM_Read_Data,
  output logic              protocol_error,
  output logic [31:0]       beats_written
);

  localparam int MEM_D = 1 << MEM_AW;
  localparam int RC_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RL_W  = (REFRESH_LEN > 1) ? $clog2(REFRESH_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_REFRESH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rst_hold_q;
  logic               wr_accept, rd_accept;
  logic               first_beat, burst_beat, last_beat, mem_we;
  logic [MEM_AW-1:0]  addr_ptr_q, wr_idx;
  logic [BURST_W-1:0] beats_left_q;
  logic [RC_W-1:0]    refresh_cnt_q;
  logic [RL_W-1:0]    refresh_len_q;
  logic               refresh_pending_q, refresh_tick, refresh_done;
  logic [DATA_W-1:0]  mem [MEM_D];
  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [DATA_W-1:0]  rd_data_q [RD_LATENCY];
  logic               unused_addr_bits;

  // Upper address bits alias onto the same backing store.
  assign unused_addr_bits = ^{DRAM_Write_Addr[ADDR_W-1:MEM_AW], DRAM_Read_Addr[ADDR_W-1:MEM_AW]};

  assign wr_accept  = DRAM_Write_Enable & ~DRAM_Wait_Request;
  assign rd_accept  = DRAM_Read_Enable & ~DRAM_Read_Wait_Request;
  assign first_beat = (state_q == S_IDLE) & wr_accept & DRAM_Write_Burst_Begin;
  assign burst_beat = (state_q == S_WR_BURST) & wr_accept;
  assign last_beat  = burst_beat & (beats_left_q == BURST_W'(1));
  assign mem_we     = first_beat | burst_beat;
  assign wr_idx     = first_beat ? DRAM_Write_Addr[MEM_AW-1:0] : addr_ptr_q;

  assign refresh_tick = (REFRESH_PERIOD != 0) && (refresh_cnt_q == RC_W'(REFRESH_PERIOD - 1));
  assign refresh_done = (state_q == S_REFRESH) && (refresh_len_q == RL_W'(REFRESH_LEN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: refresh only starts from an idle cycle with no transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (first_beat && (DRAM_Write_Burst_Count > BURST_W'(1)))
          state_d = S_WR_BURST;
        else if (refresh_pending_q && !rst_hold_q && !wr_accept && !rd_accept)
          state_d = S_REFRESH;
      end
      S_WR_BURST: if (last_beat) state_d = S_IDLE;
      S_REFRESH:  if (refresh_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: wait requests per state; a presented first beat wins over a read.
  always_comb begin
    DRAM_Wait_Request      = 1'b1;
    DRAM_Read_Wait_Request = 1'b1;
    case (state_q)
      S_IDLE: begin
        DRAM_Wait_Request      = rst_hold_q | refresh_pending_q;
        DRAM_Read_Wait_Request = rst_hold_q | refresh_pending_q |
                                 (DRAM_Write_Enable & DRAM_Write_Burst_Begin);
      end
      S_WR_BURST: begin
        DRAM_Wait_Request      = 1'b0;
        DRAM_Read_Wait_Request = 1'b1;
      end
      default: begin
        DRAM_Wait_Request      = 1'b1;
        DRAM_Read_Wait_Request = 1'b1;
      end
    endcase
  end

  // Burst bookkeeping, beat counter, sticky error flag and the one-cycle reset hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_hold_q     <= 1'b1;
      addr_ptr_q     <= '0;
      beats_left_q   <= '0;
      beats_written  <= '0;
      protocol_error <= 1'b0;
    end else begin
      rst_hold_q <= 1'b0;
      if (first_beat) begin
        addr_ptr_q   <= DRAM_Write_Addr[MEM_AW-1:0] + MEM_AW'(1);
        beats_left_q <= DRAM_Write_Burst_Count - BURST_W'(1);
      end else if (burst_beat) begin
        addr_ptr_q   <= addr_ptr_q + MEM_AW'(1);
        beats_left_q <= beats_left_q - BURST_W'(1);
      end
      if (wr_accept) beats_written <= beats_written + 32'd1;
      if ((first_beat && (DRAM_Write_Burst_Count == '0)) ||
          (burst_beat && DRAM_Write_Burst_Begin) ||
          ((state_q == S_IDLE) && wr_accept && !DRAM_Write_Burst_Begin))
        protocol_error <= 1'b1;
    end
  end

  // Free-running refresh timer; a pending request absorbs further ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q     <= '0;
      refresh_len_q     <= '0;
      refresh_pending_q <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_tick ? '0 : refresh_cnt_q + RC_W'(1);
      refresh_len_q <= (state_q == S_REFRESH) ? refresh_len_q + RL_W'(1) : '0;
      if (refresh_tick)      refresh_pending_q <= 1'b1;
      else if (refresh_done) refresh_pending_q <= 1'b0;
    end
  end

  // Backing store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= DRAM_Write_Data;
  end

  // Read pipeline: sample on acceptance, each stage's data only moves with a
  // valid token so the final stage holds the last returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= rd_accept;
      if (rd_accept) rd_data_q[0] <= mem[DRAM_Read_Addr[MEM_AW-1:0]];
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        if (rd_vld_q[i-1]) rd_data_q[i] <= rd_data_q[i-1];
      end
    end
  end

  assign DRAM_Read_Valid = rd_vld_q[RD_LATENCY-1];
  assign DRAM_Read_Data  = rd_data_q[RD_LATENCY-1];

endmodule

// File: tb/tb_dram_burst_responder.sv
// tb_dram_burst_responder
// Directed and randomized bursts/reads against a word-array model of the
// memory and a queue of expected read returns keyed by due cycle.
module tb_dram_burst_responder;

  localparam int DW   = 256;
  localparam int AW   = 25;
  localparam int BW   = 5;
  localparam int MAW  = 10;
  localparam int RL   = 4;
  localparam int RP   = 16;
  localparam int RLEN = 3;
  localparam int DEPTH = 1 << MAW;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          we, wbegin, re;
  logic [BW-1:0] wcount;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic          wr_wait, rd_wait, rd_valid, perr;
  logic [DW-1:0] rd_data;
  logic [31:0]   beats_written;

  dram_burst_responder #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MEM_AW(MAW),
    .RD_LATENCY(RL), .REFRESH_PERIOD(RP), .REFRESH_LEN(RLEN)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .DRAM_Write_Enable      (we),
    .DRAM_Write_Burst_Begin (wbegin),
    .DRAM_Write_Burst_Count (wcount),
    .DRAM_Write_Addr        (waddr),
    .DRAM_Write_Data        (wdata),
    .DRAM_Wait_Request      (wr_wait),
    .DRAM_Read_Enable       (re),
    .DRAM_Read_Addr         (raddr),
    .DRAM_Read_Wait_Request (rd_wait),
    .DRAM_Read_Valid        (rd_valid),
    .DRAM_Read_Data         (rd_data),
    .protocol_error         (perr),
    .beats_written          (beats_written)
  );

  // Model and scoreboard state
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] mem_m [DEPTH];
  int            wl[$];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  logic [DW-1:0] last_data;
  logic [31:0]   bw_m;
  logic wr_wait_s, rd_wait_s, wr_acc_s, rd_acc_s;
  int stall_v;
  int nref;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes, book transfers, then check the read return port.
  task automatic cycle();
    #1;
    wr_wait_s = wr_wait;
    rd_wait_s = rd_wait;
    wr_acc_s  = we & ~wr_wait_s;
    rd_acc_s  = re & ~rd_wait_s;
    if (rd_acc_s) begin
      exp_q.push_back(mem_m[raddr[MAW-1:0]]);
      due_q.push_back(cyc + RL);
    end
    if (wr_acc_s) bw_m = bw_m + 32'd1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("rd_valid_due", rd_valid, 1'b1);
      last_data = exp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      chk("rd_valid_idle", rd_valid, 1'b0);
    end
    chk("rd_data", rd_data, last_data);
  endtask

  task automatic idle(input int n);
    we = 1'b0; wbegin = 1'b0; re = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    exp_q.delete();
    due_q.delete();
    last_data = '0;
    bw_m = '0;
    we = 1'b0; wbegin = 1'b0; re = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wr_wait", wr_wait, 1'b1);
    chk("rst_rd_wait", rd_wait, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_beats", beats_written, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_wr_wait", wr_wait, 1'b1);
    chk("release_rd_wait", rd_wait, 1'b1);
    @(negedge clk);
    chk("post_release_wr_wait", wr_wait, 1'b0);
    chk("post_release_rd_wait", rd_wait, 1'b0);
    chk("post_release_valid", rd_valid, 1'b0);
  endtask

  // Driver: one burst of n beats; model writes word (addr+i) mod DEPTH.
  task automatic burst(input logic [AW-1:0] addr, input int n, input logic [BW-1:0] cnt_field,
                       input int mid_begin, input int gap_pct, output int stall);
    stall = 0;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      int guard;
      int idx;
      d = rand_data();
      guard = 0;
      if (i > 0) begin
        for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
          we = 1'b0; wbegin = 1'b0;
          cycle();
          chk("gap_wr_wait", wr_wait_s, 1'b0);
          chk("gap_rd_wait", rd_wait_s, 1'b1);
        end
      end
      we     = 1'b1;
      wbegin = (i == 0) || (i == mid_begin);
      wcount = (i == 0) ? cnt_field : BW'($urandom);
      waddr  = (i == 0) ? addr : AW'($urandom);
      wdata  = d;
      do begin
        cycle();
        guard++;
        if (i == 0) begin
          chk("first_beat_rd_wait", rd_wait_s, 1'b1);
        end else begin
          chk("mid_burst_wr_wait", wr_wait_s, 1'b0);
          chk("mid_burst_rd_wait", rd_wait_s, 1'b1);
        end
      end while (!wr_acc_s && guard < 40);
      chk("wr_beat_accepted", wr_acc_s, 1'b1);
      if (i == 0) stall = guard - 1;
      idx = (int'(addr[MAW-1:0]) + i) % DEPTH;
      mem_m[idx] = d;
      wl.push_back(idx);
    end
    we = 1'b0;
    wbegin = 1'b0;
  endtask

  task automatic read_one(input logic [AW-1:0] addr);
    int guard;
    guard = 0;
    re = 1'b1;
    raddr = addr;
    do begin
      cycle();
      guard++;
    end while (!rd_acc_s && guard < 40);
    chk("rd_accepted", rd_acc_s, 1'b1);
    re = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    re = 1'b0;
    we = 1'b0;
    while (due_q.size() > 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("reads_drained", due_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wbegin = 1'b0; wcount = '0; waddr = '0; wdata = '0;
    re = 1'b0; raddr = '0;
    last_data = '0;
    bw_m = '0;
    nref = 0;
    @(negedge clk);

    // Reset values and one-cycle wait release
    do_reset();

    // Burst of four at 0x10 read back in order
    burst(25'h10, 4, 5'd4, -1, 0, stall_v);
    for (int i = 0; i < 4; i++) read_one(25'h10 + AW'(i));
    drain();
    chk("beats_after_first_burst", beats_written, bw_m);

    // Read presented together with a first beat stalls until the burst ends
    re = 1'b1;
    raddr = 25'h41;
    burst(25'h40, 3, 5'd3, -1, 30, stall_v);
    read_one(25'h41);
    drain();

    // Address wrap across the top of the store, reads through aliased addresses
    burst(25'h3FE, 4, 5'd4, -1, 0, stall_v);
    read_one(25'h3FE);
    read_one(25'h1_07FF);
    read_one(25'h400);
    read_one(25'h001);
    drain();
    chk("beats_after_wrap", beats_written, bw_m);

    // Back-to-back 8-beat bursts: stalls only between bursts, one IDLE cycle plus the refresh
    for (int j = 0; j < 8; j++) begin
      burst(AW'($urandom), 8, 5'd8, -1, 0, stall_v);
      if (j > 0) begin
        chk("refresh_window", (stall_v == 0) || (stall_v == RLEN + 1), 1'b1);
        if (stall_v != 0) nref++;
      end
    end
    chk("refresh_seen", nref > 0, 1'b1);
    chk("beats_after_refresh", beats_written, bw_m);

    // Randomized bursts with gaps and aliased reads of written words
    for (int k = 0; k < 12; k++) begin
      int n;
      n = $urandom_range(1, 8);
      burst(AW'($urandom), n, BW'(n), -1, 30, stall_v);
      for (int r = 0; r < $urandom_range(1, 3); r++) begin
        int idx;
        idx = wl[$urandom_range(0, wl.size() - 1)];
        read_one({AW'($urandom_range(0, 31)) << MAW} | AW'(idx));
      end
      idle($urandom_range(0, 2));
    end
    drain();
    chk("beats_after_random", beats_written, bw_m);

    // Count=0 first beat: written as a single beat, flags an error
    burst(25'h200, 1, 5'd0, -1, 0, stall_v);
    chk("perr_count0", perr, 1'b1);
    read_one(25'h200);
    drain();
    do_reset();

    // Begin inside a burst: written as a continuation, flags an error
    burst(25'h210, 4, 5'd4, 2, 0, stall_v);
    chk("perr_mid_begin", perr, 1'b1);
    for (int i = 0; i < 4; i++) read_one(25'h210 + AW'(i));
    drain();
    do_reset();

    // Beat without Begin in IDLE is dropped and flags an error
    begin
      int guard;
      guard = 0;
      we = 1'b1; wbegin = 1'b0; wcount = 5'd1; waddr = 25'h220; wdata = rand_data();
      do begin
        cycle();
        guard++;
      end while (!wr_acc_s && guard < 40);
      we = 1'b0;
      chk("perr_no_begin", perr, 1'b1);
    end

    // Reset mid-burst with reads in flight: no stray returns, store intact
    read_one(25'h10);
    read_one(25'h11);
    begin
      int guard;
      logic [DW-1:0] d;
      guard = 0;
      d = rand_data();
      we = 1'b1; wbegin = 1'b1; wcount = 5'd8; waddr = 25'h300; wdata = d;
      do begin
        cycle();
        guard++;
      end while (!wr_acc_s && guard < 40);
      chk("pre_reset_beat_accepted", wr_acc_s, 1'b1);
      mem_m[10'h300] = d;
    end
    do_reset();
    idle(8);
    read_one(25'h300);
    drain();
    burst(25'h0FF, 2, 5'd2, -1, 0, stall_v);
    read_one(25'h0FF);
    read_one(25'h100);
    drain();
    chk("beats_after_reset_burst", beats_written, bw_m);
    chk("perr_stays_clear", perr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
